// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared defaults and FSM encoding for the debug frame path
package debug_pkg;

    localparam int NB_BYTE_DEF          = 8;
    localparam int NB_CONTROL_FRAME_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SEND = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_SEND = ST_SEND,
        S_WAIT = ST_WAIT
    } tx_state_t;

endpackage

// File: rtl/debug_sync_fifo.sv
// rtl/debug_sync_fifo.sv - single-clock frame FIFO with occupancy count
module debug_sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int LOG2_DEPTH = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_data,
    output logic [WIDTH-1:0]      o_data,
    output logic [LOG2_DEPTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int                    DEPTH    = 2**LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0]   CNT_FULL = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0]   CNT_ONE  = (LOG2_DEPTH+1)'(1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage write; when full with a pop, wr_ptr equals rd_ptr and the old head is read out before it is overwritten.
    always_ff @(posedge i_clock) begin
        if (!i_reset && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count carries the extra bit to tell full from empty.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/debug_frame_tx.sv
// rtl/debug_frame_tx.sv - buffers debug frames and serializes them MSB byte first to a UART
module debug_frame_tx
    import debug_pkg::*;
#(
    parameter int NB_CONTROL_FRAME = NB_CONTROL_FRAME_DEF,
    parameter int NB_BYTE          = NB_BYTE_DEF,
    parameter int LOG2_DEPTH       = 3
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_control,
    input  logic                        i_writing,
    output logic [NB_BYTE-1:0]          o_tx_data,
    output logic                        o_tx_start,
    input  logic                        i_tx_done,
    output logic                        o_busy,
    output logic                        o_overflow,
    output logic [LOG2_DEPTH:0]         o_fifo_count
);

    localparam int                N_BYTES   = NB_CONTROL_FRAME / NB_BYTE;
    localparam int                NB_CNT    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE   = NB_CNT'(1);

    tx_state_t                   r_state;
    tx_state_t                   w_next_state;
    logic [NB_CONTROL_FRAME-1:0] r_shift;
    logic [NB_CNT-1:0]           r_byte_cnt;
    logic                        r_overflow;
    logic                        w_pop;
    logic                        w_shift;
    logic                        w_drop;
    logic [NB_CONTROL_FRAME-1:0] w_fifo_data;
    logic [LOG2_DEPTH:0]         w_fifo_count;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;

    debug_sync_fifo #(
        .WIDTH      (NB_CONTROL_FRAME),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (i_writing),
        .i_pop   (w_pop),
        .i_data  (i_frame_from_control),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A frame is lost only when the FIFO is full and nothing leaves this cycle.
    assign w_drop = i_writing & w_fifo_full & ~w_pop;

    // Next-state logic: decides when to pop a new frame or advance to the next byte.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    if (r_byte_cnt != LAST_BYTE) begin
                        w_shift      = 1'b1;
                        w_next_state = S_SEND;
                    end else if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_SEND;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shift register and byte counter: load on pop, shift left one byte per completed byte.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (w_pop) begin
            r_shift    <= w_fifo_data;
            r_byte_cnt <= '0;
        end else if (w_shift) begin
            r_shift    <= r_shift << NB_BYTE;
            r_byte_cnt <= r_byte_cnt + CNT_ONE;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_tx_start   = (r_state == S_SEND);
    assign o_tx_data    = r_shift[NB_CONTROL_FRAME-1 -: NB_BYTE];
    assign o_busy       = ~w_fifo_empty | (r_state != S_IDLE);
    assign o_overflow   = r_overflow;
    assign o_fifo_count = w_fifo_count;

endmodule

// File: tb/tb_debug_frame_tx.sv
// tb/tb_debug_frame_tx.sv - scoreboard bench for debug_frame_tx
module tb_debug_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] frame = '0;
    logic        writing = 1'b0;
    logic        done = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        o_busy;
    logic        o_overflow;
    logic [3:0]  o_fifo_count;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    bit          resp_en = 1'b0;
    int          resp_delay = 3;
    int          start_count = 0;
    logic        prev_start = 1'b0;
    int          peak = 0;

    always #5 clk = ~clk;

    debug_frame_tx #(
        .NB_CONTROL_FRAME (32),
        .NB_BYTE          (8),
        .LOG2_DEPTH       (3)
    ) dut (
        .i_clock              (clk),
        .i_reset              (rst),
        .i_frame_from_control (frame),
        .i_writing            (writing),
        .o_tx_data            (o_tx_data),
        .o_tx_start           (o_tx_start),
        .i_tx_done            (done),
        .o_busy               (o_busy),
        .o_overflow           (o_overflow),
        .o_fifo_count         (o_fifo_count)
    );

    // Output monitor: every start pops the scoreboard.
    always @(negedge clk) begin
        if (!rst && o_tx_start) begin
            start_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL byte_unexpected got=%h expected=none", o_tx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_tx_data !== mon_exp) begin
                    failures++;
                    $display("FAIL byte_order got=%h expected=%h", o_tx_data, mon_exp);
                end
            end
            checks++;
            if (prev_start) begin
                failures++;
                $display("FAIL start_consecutive got=1 expected=0");
            end
        end
        prev_start = o_tx_start;
    end

    // UART model: done pulse resp_delay cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_en && o_tx_start && !rst) begin
                repeat (resp_delay) @(posedge clk);
                #1 done = 1'b1;
                @(posedge clk);
                #1 done = 1'b0;
            end
        end
    end

    task automatic push_frame_exp(input logic [31:0] f);
        for (int b = 3; b >= 0; b--) exp_q.push_back(f[b*8 +: 8]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        writing = 1'b0;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 done = 1'b1;
        @(posedge clk);
        #1 done = 1'b0;
        @(posedge clk);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (int'(o_fifo_count) > peak) peak = int'(o_fifo_count);
            if (exp_q.size() == 0 && !o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL drain_timeout got=pending%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 5;
        if (o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h expected=00", o_tx_data); end
        if (o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b expected=0", o_tx_start); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", o_busy); end
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b expected=0", o_overflow); end
        if (o_fifo_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d expected=0", o_fifo_count); end
    endtask

    task automatic test_single();
        resp_en = 1'b1;
        resp_delay = 3;
        @(posedge clk);
        #1 writing = 1'b1;
        frame = 32'hDEADBEEF;
        push_frame_exp(32'hDEADBEEF);
        @(posedge clk);
        #1 writing = 1'b0;
        @(negedge clk);
        checks += 2;
        if (o_fifo_count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d expected=1", o_fifo_count); end
        if (o_tx_start !== 1'b0) begin failures++; $display("FAIL single_early_start got=%b expected=0", o_tx_start); end
        @(negedge clk);
        checks++;
        if (o_tx_start !== 1'b1) begin failures++; $display("FAIL single_latency got=%b expected=1", o_tx_start); end
        wait_idle(200);
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b expected=0", o_busy); end
    endtask

    task automatic test_burst();
        int base;
        base = start_count;
        peak = 0;
        resp_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1 writing = 1'b1;
            frame = 32'(i);
            push_frame_exp(32'(i));
        end
        @(posedge clk);
        #1 writing = 1'b0;
        wait_idle(1000);
        #1;
        checks += 3;
        if (start_count - base != 32) begin failures++; $display("FAIL burst_bytes got=%0d expected=32", start_count - base); end
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL burst_overflow got=%b expected=0", o_overflow); end
        if (peak != 7 && peak != 8) begin failures++; $display("FAIL burst_peak got=%0d expected=7or8", peak); end
    endtask

    task automatic test_overflow();
        do_reset();
        resp_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 writing = 1'b1;
            frame = 32'h100 + 32'(i);
            if (i < 9) push_frame_exp(32'h100 + 32'(i));
        end
        @(posedge clk);
        #1 writing = 1'b0;
        @(negedge clk);
        checks += 2;
        if (o_fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d expected=8", o_fifo_count); end
        if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b expected=1", o_overflow); end
        repeat (5) @(negedge clk);
        checks += 2;
        if (o_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b expected=1", o_overflow); end
        if (o_fifo_count !== 4'd8) begin failures++; $display("FAIL ovf_hold got=%0d expected=8", o_fifo_count); end
    endtask

    task automatic test_full_pop();
        do_reset();
        resp_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1 writing = 1'b1;
            frame = 32'h200 + 32'(i);
            push_frame_exp(32'h200 + 32'(i));
        end
        @(posedge clk);
        #1 writing = 1'b0;
        @(negedge clk);
        checks += 2;
        if (o_fifo_count !== 4'd8) begin failures++; $display("FAIL full_fill got=%0d expected=8", o_fifo_count); end
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL full_fill_ovf got=%b expected=0", o_overflow); end
        for (int i = 0; i < 3; i++) pulse_done();
        @(posedge clk);
        #1 done = 1'b1;
        writing = 1'b1;
        frame = 32'hCAFEF00D;
        push_frame_exp(32'hCAFEF00D);
        @(posedge clk);
        #1 done = 1'b0;
        writing = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        checks += 3;
        if (o_fifo_count !== 4'd8) begin failures++; $display("FAIL full_pop_count got=%0d expected=8", o_fifo_count); end
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL full_pop_ovf got=%b expected=0", o_overflow); end
        if (o_tx_start !== 1'b1) begin failures++; $display("FAIL frame_to_frame got=%b expected=1", o_tx_start); end
        wait_idle(1000);
        checks++;
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL full_pop_end_ovf got=%b expected=0", o_overflow); end
    endtask

    task automatic test_reset_mid();
        int base;
        bit seen;
        do_reset();
        resp_en = 1'b1;
        resp_delay = 3;
        base = start_count;
        seen = 1'b0;
        @(posedge clk);
        #1 writing = 1'b1;
        frame = 32'h11223344;
        push_frame_exp(32'h11223344);
        @(posedge clk);
        #1 writing = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (start_count == base + 2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_second_start got=%0d expected=2", start_count - base); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks += 5;
        if (o_tx_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h expected=00", o_tx_data); end
        if (o_tx_start !== 1'b0) begin failures++; $display("FAIL mid_start got=%b expected=0", o_tx_start); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b expected=0", o_busy); end
        if (o_overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow got=%b expected=0", o_overflow); end
        if (o_fifo_count !== 4'd0) begin failures++; $display("FAIL mid_count got=%0d expected=0", o_fifo_count); end
        base = start_count;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (start_count != base) begin failures++; $display("FAIL mid_stale_done got=%0d expected=0", start_count - base); end
    endtask

    task automatic test_stray_done();
        int base;
        do_reset();
        resp_en = 1'b0;
        base = start_count;
        pulse_done();
        repeat (3) @(negedge clk);
        #1;
        checks += 2;
        if (start_count != base) begin failures++; $display("FAIL stray_idle got=%0d expected=0", start_count - base); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL stray_idle_busy got=%b expected=0", o_busy); end
        @(posedge clk);
        #1 writing = 1'b1;
        frame = 32'hA5A55A5A;
        push_frame_exp(32'hA5A55A5A);
        @(posedge clk);
        #1 writing = 1'b0;
        @(posedge clk);
        #1 done = 1'b1;
        @(negedge clk);
        checks++;
        if (o_tx_start !== 1'b1) begin failures++; $display("FAIL stray_send_state got=%b expected=1", o_tx_start); end
        @(posedge clk);
        #1 done = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (start_count != base + 1) begin failures++; $display("FAIL stray_send got=%0d expected=1", start_count - base); end
        for (int i = 0; i < 4; i++) pulse_done();
        wait_idle(50);
        #1;
        checks++;
        if (start_count != base + 4) begin failures++; $display("FAIL stray_total got=%0d expected=4", start_count - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_stray_done();
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
